// File: rtl/line_tracker.sv
// Line-following steering decision: synchronises and debounces the three IR sensors, then picks a motor mode.
// Optional LINE_TRACKER_SWEEP_EN: halfway through SEARCH the turn direction flips to sweep the other side.
module line_tracker #(
  parameter int unsigned STABLE_CYCLES = 100000,
  parameter int unsigned LOST_TIMEOUT  = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       left_sig,
  input  logic       mid_sig,
  input  logic       right_sig,
  output logic [1:0] mode,
  output logic       lost,
  output logic       halted,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FWD    = 3'd1,
    S_LEFT   = 3'd2,
    S_RIGHT  = 3'd3,
    S_SEARCH = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;
  logic [2:0]  r_cand;
  logic [31:0] r_cnt;
  logic [2:0]  r_filt;

  state_t      r_state;
  logic        r_last_dir;  // 0 = LEFT, 1 = RIGHT
  logic [31:0] r_lost_cnt;
  logic [1:0]  r_mode;
  logic        r_lost;
  logic        r_halted;

  state_t      w_state_nxt;
  logic [31:0] w_lost_cnt_nxt;
  logic        w_dir_nxt;
  logic [1:0]  w_mode_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_cand  <= 3'b000;
      r_cnt   <= '0;
      r_filt  <= 3'b000;
    end else begin
      r_sync1 <= {left_sig, mid_sig, right_sig};
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt == STABLE_CYCLES - 1) begin
        r_filt <= r_cand;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  // 101 is ambiguous (line under both outer sensors): keep steering if already steering.
  function automatic state_t decode(input logic [2:0] f, input state_t cur);
    case (f)
      3'b010, 3'b111: decode = S_FWD;
      3'b110, 3'b100: decode = S_LEFT;
      3'b011, 3'b001: decode = S_RIGHT;
      3'b000:         decode = S_SEARCH;
      default:        decode = (cur == S_FWD || cur == S_LEFT || cur == S_RIGHT) ? cur : S_FWD;
    endcase
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_lost_cnt_nxt = '0;
    if (!en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_FWD, S_LEFT, S_RIGHT: w_state_nxt = decode(r_filt, r_state);
        S_SEARCH: begin
          if (r_filt != 3'b000) begin
            w_state_nxt = decode(r_filt, r_state);
          end else if (r_lost_cnt == LOST_TIMEOUT - 1) begin
            w_state_nxt = S_HALT;
          end else begin
            w_state_nxt    = S_SEARCH;
            w_lost_cnt_nxt = r_lost_cnt + 32'd1;
          end
        end
        S_HALT:  w_state_nxt = (r_filt != 3'b000) ? decode(r_filt, r_state) : S_HALT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_dir_nxt = r_last_dir;
    if (w_state_nxt == S_LEFT)  w_dir_nxt = 1'b0;
    if (w_state_nxt == S_RIGHT) w_dir_nxt = 1'b1;
  end

  always_comb begin
    w_mode_nxt = 2'b00;
    case (w_state_nxt)
      S_FWD:   w_mode_nxt = 2'b01;
      S_LEFT:  w_mode_nxt = 2'b10;
      S_RIGHT: w_mode_nxt = 2'b11;
`ifdef LINE_TRACKER_SWEEP_EN
      S_SEARCH: w_mode_nxt = (w_lost_cnt_nxt >= LOST_TIMEOUT / 2) ? {1'b1, ~r_last_dir}
                                                                  : {1'b1, r_last_dir};
`else
      S_SEARCH: w_mode_nxt = {1'b1, r_last_dir};
`endif
      default: w_mode_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_dir <= 1'b0;
      r_lost_cnt <= '0;
      r_mode     <= 2'b00;
      r_lost     <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_dir <= w_dir_nxt;
      r_lost_cnt <= w_lost_cnt_nxt;
      r_mode     <= w_mode_nxt;
      r_lost     <= (w_state_nxt == S_SEARCH) || (w_state_nxt == S_HALT);
      r_halted   <= (w_state_nxt == S_HALT);
    end
  end

  assign mode        = r_mode;
  assign lost        = r_lost;
  assign halted      = r_halted;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_line_tracker.sv
// Bench for line_tracker with STABLE_CYCLES=4, LOST_TIMEOUT=20; follows LINE_TRACKER_SWEEP_EN when defined.
// Edge numbering per scenario: edge e is the e-th posedge after the first stimulus of that phase.
module tb_line_tracker;

  localparam int unsigned SC = 4;
  localparam int unsigned LT = 20;

  logic       clk;
  logic       rst;
  logic       en;
  logic       left_sig;
  logic       mid_sig;
  logic       right_sig;
  logic [1:0] mode;
  logic       lost;
  logic       halted;
  logic [2:0] dbg_state;

  logic [3:0] exp_q[$];  // {mode, lost, halted}
  logic [3:0] exp_v;
  int total;
  int bad;

  line_tracker #(.STABLE_CYCLES(SC), .LOST_TIMEOUT(LT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .left_sig(left_sig), .mid_sig(mid_sig), .right_sig(right_sig),
    .mode(mode), .lost(lost), .halted(halted), .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic e, input logic [2:0] sens);
    rst = r;
    en  = e;
    {left_sig, mid_sig, right_sig} = sens;
  endtask

  function automatic logic [3:0] pk(input logic [1:0] m, input logic l, input logic h);
    return {m, l, h};
  endfunction

  // Expected mode idx cycles after entering SEARCH with the given last turn (0=LEFT,1=RIGHT).
  function automatic logic [1:0] search_mode(input logic dir, input int idx);
`ifdef LINE_TRACKER_SWEEP_EN
    if (idx >= int'(LT / 2)) return {1'b1, ~dir};
`endif
    return {1'b1, dir};
  endfunction

  task automatic test_reset();
    for (int e = 1; e <= 3; e++) begin
      drive(1'b1, 1'b0, 3'b000);
      exp_q.push_back(pk(2'b00, 1'b0, 1'b0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({mode, lost, halted} !== exp_v) begin
        bad++;
        $display("FAIL reset e=%0d got=%b exp=%b", e, {mode, lost, halted}, exp_v);
      end
      total++;
      if (dbg_state !== 3'd0) begin
        bad++;
        $display("FAIL reset_state e=%0d got=%0d exp=0", e, dbg_state);
      end
    end
  endtask

  task automatic test_forward();
    for (int e = 1; e <= 12; e++) begin
      drive(1'b0, (e >= 8), 3'b010);
      exp_q.push_back((e < 8) ? pk(2'b00, 1'b0, 1'b0) : pk(2'b01, 1'b0, 1'b0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({mode, lost, halted} !== exp_v) begin
        bad++;
        $display("FAIL forward e=%0d got=%b exp=%b", e, {mode, lost, halted}, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    for (int e = 1; e <= 14; e++) begin
      drive(1'b0, 1'b1, (e >= 3 && e <= 5) ? 3'b110 : 3'b010);
      exp_q.push_back(pk(2'b01, 1'b0, 1'b0));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({mode, lost, halted} !== exp_v) begin
        bad++;
        $display("FAIL glitch e=%0d got=%b exp=%b", e, {mode, lost, halted}, exp_v);
      end
    end
  endtask

  task automatic test_search_halt();
    for (int e = 1; e <= 50; e++) begin
      if (e <= 10) begin
        drive(1'b0, 1'b1, 3'b110);
        exp_q.push_back((e < 8) ? pk(2'b01, 1'b0, 1'b0) : pk(2'b10, 1'b0, 1'b0));
      end else if (e <= 40) begin
        drive(1'b0, 1'b1, 3'b000);
        if (e - 10 < 8)       exp_q.push_back(pk(2'b10, 1'b0, 1'b0));
        else if (e - 10 < 28) exp_q.push_back(pk(search_mode(1'b0, e - 18), 1'b1, 1'b0));
        else                  exp_q.push_back(pk(2'b00, 1'b1, 1'b1));
      end else begin
        drive(1'b0, 1'b1, 3'b011);
        exp_q.push_back((e - 40 < 8) ? pk(2'b00, 1'b1, 1'b1) : pk(2'b11, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({mode, lost, halted} !== exp_v) begin
        bad++;
        $display("FAIL search_halt e=%0d got=%b exp=%b", e, {mode, lost, halted}, exp_v);
      end
    end
  endtask

  task automatic test_en_drop();
    for (int e = 1; e <= 35; e++) begin
      drive(1'b0, !(e == 13 || e == 14), 3'b000);
      if (e < 8)       exp_q.push_back(pk(2'b11, 1'b0, 1'b0));
      else if (e < 13) exp_q.push_back(pk(search_mode(1'b1, e - 8), 1'b1, 1'b0));
      else if (e < 15) exp_q.push_back(pk(2'b00, 1'b0, 1'b0));
      else if (e < 35) exp_q.push_back(pk(search_mode(1'b1, e - 15), 1'b1, 1'b0));
      else             exp_q.push_back(pk(2'b00, 1'b1, 1'b1));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({mode, lost, halted} !== exp_v) begin
        bad++;
        $display("FAIL en_drop e=%0d got=%b exp=%b", e, {mode, lost, halted}, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int e = 1; e <= 31; e++) begin
      drive((e == 10), 1'b1, (e < 10) ? 3'b001 : 3'b000);
      if (e < 8)       exp_q.push_back(pk(2'b00, 1'b1, 1'b1));
      else if (e < 10) exp_q.push_back(pk(2'b11, 1'b0, 1'b0));
      else if (e < 11) exp_q.push_back(pk(2'b00, 1'b0, 1'b0));
      else if (e < 31) exp_q.push_back(pk(search_mode(1'b0, e - 11), 1'b1, 1'b0));
      else             exp_q.push_back(pk(2'b00, 1'b1, 1'b1));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      total++;
      if ({mode, lost, halted} !== exp_v) begin
        bad++;
        $display("FAIL reset_mid e=%0d got=%b exp=%b", e, {mode, lost, halted}, exp_v);
      end
      if (e == 10) begin
        total++;
        if (dbg_state !== 3'd0) begin
          bad++;
          $display("FAIL reset_mid_state got=%0d exp=0", dbg_state);
        end
      end
    end
  endtask

  task automatic test_decode();
    logic [2:0] pats [7];
    logic [1:0] mods [7];
    logic [3:0] prev;
    pats = '{3'b101, 3'b100, 3'b101, 3'b011, 3'b101, 3'b111, 3'b110};
    mods = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10};
    prev = pk(2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      for (int e = 1; e <= 10; e++) begin
        drive(1'b0, 1'b1, pats[i]);
        exp_q.push_back((e < 8) ? prev : pk(mods[i], 1'b0, 1'b0));
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        total++;
        if ({mode, lost, halted} !== exp_v) begin
          bad++;
          $display("FAIL decode pat=%b e=%0d got=%b exp=%b", pats[i], e, {mode, lost, halted}, exp_v);
        end
      end
      prev = pk(mods[i], 1'b0, 1'b0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b1, 1'b0, 3'b000);
    test_reset();
    test_forward();
    test_glitch();
    test_search_halt();
    test_en_drop();
    test_reset_mid();
    test_decode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
